// File: rtl/layer_mac_sequencer_pkg.sv
// Layer geometry, derived widths and FSM state encoding for layer_mac_sequencer.
package layer_mac_sequencer_pkg;

    localparam int unsigned N_IN  = 30;
    localparam int unsigned N_OUT = 8;
    localparam int unsigned AW    = $clog2(N_OUT * (N_IN + 1));
    localparam int unsigned NW    = $clog2(N_OUT);
    localparam int unsigned KW    = $clog2(N_IN + 1);
    localparam int unsigned CW    = $clog2(N_IN);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_MAC,
        ST_OUT
    } state_t;

endpackage

// File: rtl/nn_pkg.sv
// Shared arithmetic for the ECG network: types and the exact node math used by
// both the parallel node modules and the time-multiplexed layer sequencer.
package nn_pkg;

    localparam int unsigned DW = 16;

    typedef logic signed [DW-1:0] act_t;
    typedef logic signed [DW-1:0] wgt_t;

    // ReLU on a 16-bit two's complement value; negative values clamp to zero.
    function automatic logic [DW-1:0] relu16(input act_t x);
        return x[DW-1] ? {DW{1'b0}} : $unsigned(x);
    endfunction

    // Signed 16x16 multiply keeping only the low 16 bits of the product.
    function automatic act_t mul_trunc16(input act_t a, input wgt_t b);
        logic signed [2*DW-1:0] p;
        p = (2*DW)'(a) * (2*DW)'(b);
        return act_t'(p[DW-1:0]);
    endfunction

endpackage

// File: rtl/layer_mac_sequencer_if.sv
// Activation input stream, weight ROM port and result output stream of one layer.
interface layer_mac_sequencer_if;
    import nn_pkg::*;
    import layer_mac_sequencer_pkg::*;

    logic            in_valid;
    logic            in_ready;
    act_t            in_data;
    logic [AW-1:0]   w_addr;
    wgt_t            w_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [NW-1:0]   out_idx;
    logic            out_last;
    logic            busy;

    modport slave (
        input  in_valid, in_data, w_rdata, out_ready,
        output in_ready, w_addr, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output in_valid, in_data, w_rdata, out_ready,
        input  in_ready, w_addr, out_valid, out_data, out_idx, out_last, busy
    );

endinterface

// File: rtl/nn_mac16.sv
// Registered multiply-truncate-accumulate with synchronous clear and enable.
// acc_nxt_c exposes the value the accumulator takes on an enabled edge.
module nn_mac16
    import nn_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic sel_bias,
    input  act_t a,
    input  wgt_t b,
    output act_t acc_nxt_c
);

    act_t acc;
    act_t term_c;

    // Next accumulator value: bias added directly, weights through the truncating multiply.
    always_comb begin
        term_c    = sel_bias ? act_t'(b) : mul_trunc16(a, b);
        acc_nxt_c = acc + term_c;
    end

    // 16-bit wrapping accumulator; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt_c;
        end
    end

endmodule

// File: rtl/layer_mac_sequencer.sv
// Time-multiplexed fully-connected layer: buffers one activation vector, then
// walks every node through a single MAC fed by an external synchronous ROM.
module layer_mac_sequencer
    import nn_pkg::*;
    import layer_mac_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    layer_mac_sequencer_if.slave bus
);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [NW-1:0]   node;
    logic [KW-1:0]   k;
    logic [KW-1:0]   d_k;
    logic            a_vld;
    logic            d_vld;
    act_t            act [N_IN];

    logic            in_hs_c;
    logic            load_done_c;
    logic            out_hs_c;
    logic            node_done_c;
    logic            mac_clr_c;
    logic            mac_en_c;
    logic            sel_bias_c;
    act_t            mac_a_c;
    act_t            acc_nxt_c;

    // Handshakes and MAC control; d_k tracks which ROM word is on w_rdata this cycle.
    always_comb begin
        in_hs_c     = bus.in_valid && bus.in_ready;
        load_done_c = (state == ST_LOAD) && in_hs_c && (cnt == CW'(N_IN - 1));
        out_hs_c    = (state == ST_OUT) && bus.out_valid && bus.out_ready;
        mac_en_c    = (state == ST_MAC) && d_vld;
        sel_bias_c  = (d_k == KW'(N_IN));
        node_done_c = mac_en_c && sel_bias_c;
        mac_clr_c   = load_done_c || (out_hs_c && (node != NW'(N_OUT - 1)));
        mac_a_c     = (d_k < KW'(N_IN)) ? act[d_k[CW-1:0]] : '0;
    end

    // Activation buffer, written only while loading.
    always_ff @(posedge clk) begin
        if ((state == ST_LOAD) && in_hs_c) begin
            act[cnt] <= bus.in_data;
        end
    end

    // Sequencer FSM with registered stream, ROM address and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_LOAD;
            cnt           <= '0;
            node          <= '0;
            k             <= '0;
            d_k           <= '0;
            a_vld         <= 1'b0;
            d_vld         <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.w_addr    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_hs_c) begin
                        bus.busy <= 1'b1;
                        if (load_done_c) begin
                            state        <= ST_MAC;
                            cnt          <= '0;
                            node         <= '0;
                            k            <= '0;
                            a_vld        <= 1'b1;
                            bus.w_addr   <= '0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    // Address issue runs two cycles ahead of accumulation (ROM latency).
                    d_vld <= a_vld;
                    d_k   <= k;
                    if (a_vld) begin
                        if (k == KW'(N_IN)) begin
                            a_vld <= 1'b0;
                        end else begin
                            k          <= k + KW'(1);
                            bus.w_addr <= bus.w_addr + AW'(1);
                        end
                    end
                    if (node_done_c) begin
                        state         <= ST_OUT;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= relu16(acc_nxt_c);
                        bus.out_idx   <= node;
                        bus.out_last  <= (node == NW'(N_OUT - 1));
                    end
                end
                ST_OUT: begin
                    if (out_hs_c) begin
                        bus.out_valid <= 1'b0;
                        if (node == NW'(N_OUT - 1)) begin
                            state        <= ST_LOAD;
                            cnt          <= '0;
                            bus.in_ready <= 1'b1;
                            bus.busy     <= 1'b0;
                        end else begin
                            state      <= ST_MAC;
                            node       <= node + NW'(1);
                            k          <= '0;
                            a_vld      <= 1'b1;
                            bus.w_addr <= AW'((32'(node) + 32'd1) * (N_IN + 32'd1));
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    nn_mac16 u_mac (
        .clk       (clk),
        .reset     (reset),
        .clr       (mac_clr_c),
        .en        (mac_en_c),
        .sel_bias  (sel_bias_c),
        .a         (mac_a_c),
        .b         (bus.w_rdata),
        .acc_nxt_c (acc_nxt_c)
    );

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer with a behavioural synchronous weight ROM.
module tb_layer_mac_sequencer;
    import nn_pkg::*;
    import layer_mac_sequencer_pkg::*;

    localparam int unsigned NB  = N_IN + 1;
    localparam int          LAT = N_IN + 2;

    logic clk = 1'b0;
    logic reset;

    layer_mac_sequencer_if bus();

    layer_mac_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] rom [N_OUT*NB];

    // Synchronous ROM: word valid one clock after the address.
    always @(posedge clk) bus.w_rdata <= rom[bus.w_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int acts    [N_IN];
    int exp_out [N_OUT];
    int in_done_cyc;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: 16-bit wrapping sum of truncated products plus bias, then ReLU.
    function automatic int model(input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < N_IN; i++)
            acc = (acc + acts[i] * int'(rom[n*NB+i])) & 32'hFFFF;
        acc = (acc + int'(rom[n*NB+N_IN])) & 32'hFFFF;
        return (acc >= 32768) ? 0 : acc;
    endfunction

    task automatic fill_rom(input int w, input int b);
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) rom[n*NB+i] = 16'(w);
            rom[n*NB+N_IN] = 16'(b);
        end
    endtask

    task automatic fill_acts(input int a);
        for (int i = 0; i < N_IN; i++) acts[i] = a;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_out_valid"}, int'(bus.out_valid), 0);
        chk({name, "_out_data"},  int'(bus.out_data), 0);
        chk({name, "_out_idx"},   int'(bus.out_idx), 0);
        chk({name, "_out_last"},  int'(bus.out_last), 0);
        chk({name, "_w_addr"},    int'(bus.w_addr), 0);
        chk({name, "_busy"},      int'(bus.busy), 0);
        chk({name, "_in_ready"},  int'(bus.in_ready), 1);
    endtask

    task automatic send_vector();
        int b;
        for (int i = 0; i < N_IN; i++) begin
            b = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(acts[i]);
            while (!bus.in_ready && b < 100) begin
                @(posedge clk); #1;
                b++;
            end
            if (b >= 100) chk("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
            if (i == 0) chk("busy_partial", int'(bus.busy), 1);
        end
        bus.in_valid = 1'b0;
        in_done_cyc  = cyc;
    endtask

    // Accept all N_OUT results; optionally stall 10 cycles on stall_node.
    task automatic collect(input int stall_node, input string name);
        int hs_cyc;
        int b;
        bit stable;
        hs_cyc = in_done_cyc;
        bus.out_ready = 1'b0;
        for (int n = 0; n < N_OUT; n++) begin
            b = 0;
            while (!bus.out_valid && b < 200) begin
                @(posedge clk); #1;
                b++;
            end
            if (!bus.out_valid) begin
                chk({name, "_valid_timeout"}, 0, 1);
                return;
            end
            chk({name, "_latency"}, cyc - hs_cyc, LAT);
            chk({name, "_data"}, int'(bus.out_data), exp_out[n]);
            chk({name, "_idx"},  int'(bus.out_idx), n);
            chk({name, "_last"}, int'(bus.out_last), (n == N_OUT - 1) ? 1 : 0);
            if (n == stall_node) begin
                stable = 1'b1;
                repeat (10) begin
                    @(posedge clk); #1;
                    if (!(bus.out_valid && int'(bus.out_data) == exp_out[n] &&
                          int'(bus.out_idx) == n && !bus.in_ready))
                        stable = 1'b0;
                end
                chk({name, "_stall_hold"}, int'(stable), 1);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            hs_cyc = cyc;
        end
        chk({name, "_in_ready_after"}, int'(bus.in_ready), 1);
        chk({name, "_busy_after"},     int'(bus.busy), 0);
    endtask

    initial begin
        int bias1 [N_OUT];
        int seen;
        bias1 = '{90, -5, 1, -1, 32767, -32768, 100, 0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        fill_rom(0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("reset");

        // Zero activations: result is ReLU of the bias alone.
        fill_acts(0);
        fill_rom(1234, 0);
        for (int n = 0; n < N_OUT; n++) rom[n*NB+N_IN] = 16'(bias1[n]);
        exp_out = '{90, 0, 1, 0, 32767, 0, 100, 0};
        send_vector();
        collect(-1, "bias_only");

        // 2*3*30+5 = 185 everywhere; node 3 stalled for 10 cycles.
        fill_acts(2);
        fill_rom(3, 5);
        exp_out = '{185, 185, 185, 185, 185, 185, 185, 185};
        send_vector();
        collect(3, "uniform");

        // 1*(-10)*30 = -300 clamps to zero.
        fill_acts(1);
        fill_rom(-10, 0);
        exp_out = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_vector();
        collect(-1, "negative");

        // 256*256 truncates to 0; only the bias survives.
        fill_acts(256);
        fill_rom(256, 7);
        exp_out = '{7, 7, 7, 7, 7, 7, 7, 7};
        send_vector();
        collect(-1, "trunc");

        // 0x4000*2 = 0x8000 per term; 30 terms wrap to 0, leaving bias 0x1234.
        fill_acts(16'h4000);
        fill_rom(2, 16'h1234);
        exp_out = '{4660, 4660, 4660, 4660, 4660, 4660, 4660, 4660};
        send_vector();
        collect(-1, "wrap");

        // Mixed-sign vector with per-node weights, checked against the wrap model.
        for (int i = 0; i < N_IN; i++) acts[i] = i * 1000 - 7;
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) rom[n*NB+i] = 16'((n + 1) * (i - 15) * 37);
            rom[n*NB+N_IN] = 16'(n * 100 - 50);
        end
        for (int n = 0; n < N_OUT; n++) exp_out[n] = model(n);
        send_vector();
        collect(-1, "mixed");

        // Reset during MAC of node 2 discards everything.
        send_vector();
        bus.out_ready = 1'b1;
        repeat (2 * (LAT + 1) + 10) @(posedge clk);
        #1;
        chk("pre_reset_busy", int'(bus.busy), 1);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("mid_mac_reset");
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        chk("no_pulse_after_reset", seen, 0);

        for (int i = 0; i < N_IN; i++) acts[i] = 4000 - i * 311;
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) rom[n*NB+i] = 16'(i * 7 + n * 13 - 90);
            rom[n*NB+N_IN] = 16'(200 * n - 700);
        end
        for (int n = 0; n < N_OUT; n++) exp_out[n] = model(n);
        send_vector();
        collect(-1, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
